if_id_inst_buffer: RTL



---
 rtl/if_id_inst_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_id_inst_buffer.sv
// if_id_inst_buffer
// Instruction buffer between fetch and decode: a small circular FIFO holding
// instruction word, PC and branch-prediction tag. The oldest entry is shown to
// decode, or a canonical NOP when the buffer is empty. A full buffer freezes
// fetch. An EX branch redirect or an interrupt discards every entry.
module if_id_inst_buffer #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Fetch_Valid,
    input  logic [31:0]      Fetch_Inst,
    input  logic [31:0]      Fetch_PC,
    input  logic             Fetch_Pred_Taken,
    input  logic             Branch_Taken__EX_MEM,
    input  logic             PC_Control__IRQ,
    input  logic             Decode_Stall,
    output logic             IF_ID_Freeze,
    output logic [31:0]      Inst__ID,
    output logic [31:0]      PC__ID,
    output logic [31:0]      PC_4__ID,
    output logic             Pred_Taken__ID,
    output logic             Valid__ID,
    output logic [PTR_W:0]   Count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // Entry storage
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        pred_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic full;
    logic empty;
    logic flush;
    logic push;
    logic pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign flush = Branch_Taken__EX_MEM | PC_Control__IRQ;
    assign push  = Fetch_Valid & ~full;
    assign pop   = ~empty & ~Decode_Stall;

    // Freeze looks only at registered occupancy; a same-cycle pop does not release it.
    assign IF_ID_Freeze = full;
    assign Count        = count;

    // Pointer and occupancy update: reset, then flush, then push/pop
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Entry write at the tail; a word arriving with a flush is wrong-path and is not stored
    always_ff @(posedge CLK) begin
        // NOTE: storage has no reset; entries are only visible through count, so clearing them buys nothing.
        if (RST && push && !flush) begin
            inst_mem[wr_ptr] <= Fetch_Inst;
            pc_mem[wr_ptr]   <= Fetch_PC;
            pred_mem[wr_ptr] <= Fetch_Pred_Taken;
        end
    end

    // Head presentation, forced to a NOP bundle when empty
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        Inst__ID       = NOP_INST;
        PC__ID         = '0;
        PC_4__ID       = '0;
        Pred_Taken__ID = 1'b0;
        Valid__ID      = 1'b0;
        if (!empty) begin
            Inst__ID       = inst_mem[rd_ptr];
            PC__ID         = pc_mem[rd_ptr];
            PC_4__ID       = pc_mem[rd_ptr] + 32'd4;  // carry out of bit 31 wraps
            Pred_Taken__ID = pred_mem[rd_ptr];
            Valid__ID      = 1'b1;
        end
    end

endmodule
